mul_div_unit: RTL

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mul_div_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation codes
// and FSM state encoding.
package mdu_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_DIV  = 2'b10,
        OP_REM  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WB   = 2'b10
    } state_e;

    function automatic logic is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_REM);
    endfunction

endpackage : mdu_pkg

// File: rtl/mul_div_unit.sv
// Iterative unsigned multiply/divide unit: shift-add multiply and restoring
// divide, one bit per cycle, single-cycle write-back strobe to the GPR file.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  opa,
    input  logic [WIDTH-1:0]  opb,
    input  logic [ADDR_W-1:0] dest,
    output logic              busy,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_dest,
    output logic [WIDTH-1:0]  wb_data
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e              r_state;
    op_e                 r_op;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_dest;
    logic [WIDTH-1:0]    r_opnd;
    logic [WIDTH-1:0]    r_hi;
    logic [WIDTH-1:0]    r_lo;
    logic                r_wb_en;
    logic [ADDR_W-1:0]   r_wb_dest;
    logic [WIDTH-1:0]    r_wb_data;

    logic [WIDTH:0]      w_mul_sum;
    logic [WIDTH:0]      w_div_shift;
    logic                w_div_ge;
    logic [WIDTH-1:0]    w_div_diff;
    logic [WIDTH-1:0]    w_result;

    // MUL: {r_hi,r_lo} is the product/multiplier pair, r_opnd the multiplicand.
    // DIV: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    always_comb begin
        w_mul_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opnd} : '0);
        w_div_shift = {r_hi, r_lo[WIDTH-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
        // When the subtraction is taken the difference is below the divisor,
        // so the low WIDTH bits hold it exactly.
        w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
        case (r_op)
            OP_MULH, OP_REM: w_result = r_hi;
            default:         w_result = r_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state   <= ST_IDLE;
            r_op      <= OP_MUL;
            r_cnt     <= '0;
            r_dest    <= '0;
            r_opnd    <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_wb_en   <= 1'b0;
            r_wb_dest <= '0;
            r_wb_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_dest  <= dest;
                        r_cnt   <= '0;
                        r_hi    <= '0;
                        r_state <= ST_RUN;
                        if (is_div(op_e'(op))) begin
                            r_opnd <= opb;
                            r_lo   <= opa;
                        end else begin
                            r_opnd <= opa;
                            r_lo   <= opb;
                        end
                    end
                end
                ST_RUN: begin
                    if (r_cnt == CNT_W'(WIDTH)) begin
                        r_wb_en   <= 1'b1;
                        r_wb_dest <= r_dest;
                        r_wb_data <= w_result;
                        r_state   <= ST_WB;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (is_div(r_op)) begin
                            // A zero divisor always subtracts: quotient all-ones, remainder = dividend.
                            if (w_div_ge) begin
                                r_hi <= w_div_diff;
                                r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                            end else begin
                                r_hi <= w_div_shift[WIDTH-1:0];
                                r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                            end
                        end else begin
                            {r_hi, r_lo} <= {w_mul_sum, r_lo[WIDTH-1:1]};
                        end
                    end
                end
                ST_WB: begin
                    r_wb_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_wb_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = (r_state != ST_IDLE);
    assign wb_en   = r_wb_en;
    assign wb_dest = r_wb_dest;
    assign wb_data = r_wb_data;

endmodule : mul_div_unit
